sclk_burst_gen: RTL

SCLK_BURST_GEN -- requirements
Module: sclk_burst_gen

---
 rtl/sclk_burst_gen.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sclk_burst_gen.sv
// -----------------------------------------------------------------------------
// sclk_burst_gen
//
// Generates a burst of N pulses on a divided serial clock. Each pulse is H clk
// cycles low followed by H clk cycles high, so the period is 2*H at 50 % duty.
// H and N are captured when the burst starts. Changes to them while a burst is
// running have no effect.
//
// Parameters
//   HP_W           width of the half-period field (clk cycles)
//   CNT_W          width of the pulse-count field
//
// Ports
//   clk            single clock, all state updates on its rising edge
//   nrst           asynchronous active-low reset
//   i_start        one-cycle request to begin a burst (only honoured in IDLE)
//   i_abort        ends a running burst (LOW/HIGH) without o_done
//   i_half_period  H, clk cycles per sclk half-period (0 is treated as 1)
//   i_n_pulses     N, sclk pulses per burst (0 gives an immediate o_done)
//   o_sclk         registered divided clock, high only in HIGH
//   o_rise         one-cycle strobe in the first HIGH cycle of each pulse
//   o_busy         high while in LOW or HIGH
//   o_done         one-cycle completion pulse (DONE state)
//   o_pulse_idx    number of pulses completed in the current burst
// -----------------------------------------------------------------------------
module sclk_burst_gen #(
    parameter int HP_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [HP_W-1:0]  i_half_period,
    input  logic [CNT_W-1:0] i_n_pulses,
    output logic             o_sclk,
    output logic             o_rise,
    output logic             o_busy,
    output logic             o_done,
    output logic [CNT_W-1:0] o_pulse_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_reg;
    logic [HP_W-1:0]  h_reg;
    logic [CNT_W-1:0] n_reg;
    logic [HP_W-1:0]  phase_reg;

    // Effective half-period: a latched H of 0 behaves like 1.
    logic [HP_W-1:0]  h_eff;
    logic [HP_W-1:0]  h_last;
    logic             phase_last;
    // One bit wider so the "more pulses to go" test cannot overflow at N max.
    logic [CNT_W:0]   pulse_inc;

    assign h_eff      = (h_reg == '0) ? {{(HP_W-1){1'b0}}, 1'b1} : h_reg;
    assign h_last     = h_eff - {{(HP_W-1){1'b0}}, 1'b1};
    assign phase_last = (phase_reg == h_last);
    assign pulse_inc  = {1'b0, o_pulse_idx} + {{CNT_W{1'b0}}, 1'b1};

    // Outputs are registered alongside the state, so every output is set from
    // the state being entered rather than decoded from state_reg afterwards.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg   <= S_IDLE;
            h_reg       <= '0;
            n_reg       <= '0;
            phase_reg   <= '0;
            o_sclk      <= 1'b0;
            o_rise      <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pulse_idx <= '0;
        end else begin
            o_rise <= 1'b0;
            o_done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (i_start) begin
                        h_reg       <= i_half_period;
                        n_reg       <= i_n_pulses;
                        phase_reg   <= '0;
                        o_pulse_idx <= '0;
                        o_sclk      <= 1'b0;
                        if (i_n_pulses == '0) begin
                            state_reg <= S_DONE;
                            o_busy    <= 1'b0;
                            o_done    <= 1'b1;
                        end else begin
                            state_reg <= S_LOW;
                            o_busy    <= 1'b1;
                        end
                    end
                end
                S_LOW: begin
                    if (i_abort) begin
                        state_reg <= S_IDLE;
                        o_sclk    <= 1'b0;
                        o_busy    <= 1'b0;
                    end else if (phase_last) begin
                        state_reg <= S_HIGH;
                        phase_reg <= '0;
                        o_sclk    <= 1'b1;
                        o_rise    <= 1'b1;
                    end else begin
                        phase_reg <= phase_reg + {{(HP_W-1){1'b0}}, 1'b1};
                    end
                end
                S_HIGH: begin
                    if (i_abort) begin
                        state_reg <= S_IDLE;
                        o_sclk    <= 1'b0;
                        o_busy    <= 1'b0;
                    end else if (phase_last) begin
                        phase_reg   <= '0;
                        o_sclk      <= 1'b0;
                        o_pulse_idx <= pulse_inc[CNT_W-1:0];
                        if (pulse_inc < {1'b0, n_reg}) begin
                            state_reg <= S_LOW;
                        end else begin
                            state_reg <= S_DONE;
                            o_busy    <= 1'b0;
                            o_done    <= 1'b1;
                        end
                    end else begin
                        phase_reg <= phase_reg + {{(HP_W-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    // Completion always finishes; start and abort are ignored.
                    state_reg <= S_IDLE;
                    o_sclk    <= 1'b0;
                    o_busy    <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                    o_sclk    <= 1'b0;
                    o_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
